// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the score display controller:
// segment glyphs (active-low gfedcba), phase and converter state encodings.
package score_disp_pkg;

    localparam int SCORE_W = 14;
    localparam int BCD_W   = 16;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_O     = 7'b0100011;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic {PH_NUMBER, PH_TEXT} phase_e;

    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_COMMIT} cv_state_e;

    function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] v);
        return (v > SCORE_MAX) ? SCORE_MAX : v;
    endfunction

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return GLYPH_0;
            4'd1:    return GLYPH_1;
            4'd2:    return GLYPH_2;
            4'd3:    return GLYPH_3;
            4'd4:    return GLYPH_4;
            4'd5:    return GLYPH_5;
            4'd6:    return GLYPH_6;
            4'd7:    return GLYPH_7;
            4'd8:    return GLYPH_8;
            4'd9:    return GLYPH_9;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    // "SCor" reads left to right, so the units position carries 'r'.
    function automatic logic [6:0] text_glyph(input logic [1:0] idx);
        case (idx)
            2'd3:    return GLYPH_S;
            2'd2:    return GLYPH_C;
            2'd1:    return GLYPH_O;
            default: return GLYPH_R;
        endcase
    endfunction

endpackage

// File: rtl/score_display_ctrl_bin2bcd.sv
// Sequential 14-bit double-dabble converter: clamps the accepted score to 9999,
// performs 14 add-3/shift steps, then presents the BCD result for one COMMIT cycle.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [SCORE_W-1:0] bin_i,
    output logic               ready_o,
    output logic               done_o,
    output logic [BCD_W-1:0]   bcd_o
);

    localparam int SR_W = BCD_W + SCORE_W;

    cv_state_e         state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        cnt_q, cnt_d;

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [BCD_W-1:0] b;
        b = sr[SR_W-1:SCORE_W];
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                b[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return {b, sr[SCORE_W-1:0]} << 1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CV_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ready_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            CV_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    sr_d    = {{BCD_W{1'b0}}, clamp_score(bin_i)};
                    cnt_d   = '0;
                    state_d = CV_SHIFT;
                end
            end
            CV_SHIFT: begin
                sr_d  = dabble_step(sr_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = CV_COMMIT;
                end
            end
            CV_COMMIT: begin
                done_o  = 1'b1;
                state_d = CV_IDLE;
            end
            default: state_d = CV_IDLE;
        endcase
    end

    assign bcd_o = sr_q[SR_W-1:SCORE_W];

endmodule

// File: rtl/score_display_ctrl.sv
// Four-digit multiplexed seven-segment score display: accepts a binary score,
// converts it to BCD, scans the digits with leading-zero blanking and alternates with "SCor".
module score_display_ctrl
    import score_disp_pkg::*;
#(
    parameter int REFRESH_DIV      = 50000,
    parameter int FRAMES_PER_PHASE = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic               text_en,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (FRAMES_PER_PHASE > 1) ? $clog2(FRAMES_PER_PHASE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_PHASE - 1);

    logic               cv_done;
    logic [BCD_W-1:0]   cv_bcd;

    logic [PW-1:0]      presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [FW-1:0]      frame_q, frame_d;
    phase_e             phase_q, phase_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic               text_en_q;

    logic               tc;
    logic               blank3, blank2, blank1, blank_cur;
    logic [FW-1:0]      frame_base;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (score_valid),
        .bin_i   (score_in),
        .ready_o (score_ready),
        .done_o  (cv_done),
        .bcd_o   (cv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            phase_q   <= PH_NUMBER;
            bcd_q     <= '0;
            seg_q     <= GLYPH_BLANK;
            an_q      <= 4'hF;
            text_en_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            text_en_q <= text_en;
        end
    end

    // Blanking cascades from the thousands digit down; units are never blanked.
    assign blank3 = (bcd_q[15:12] == 4'd0);
    assign blank2 = blank3 && (bcd_q[11:8] == 4'd0);
    assign blank1 = blank2 && (bcd_q[7:4] == 4'd0);
    assign tc     = (presc_q == PRESC_LAST);

    always_comb begin
        case (idx_q)
            2'd3:    blank_cur = blank3;
            2'd2:    blank_cur = blank2;
            2'd1:    blank_cur = blank1;
            default: blank_cur = 1'b0;
        endcase
    end

    always_comb begin
        presc_d    = tc ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        phase_d    = phase_q;
        seg_d      = seg_q;
        an_d       = an_q;
        bcd_d      = cv_done ? cv_bcd : bcd_q;
        frame_base = (text_en && !text_en_q) ? '0 : frame_q;
        frame_d    = frame_base;

        if (tc) begin
            // Outputs register the digit at the current index while the index moves on,
            // so a new BCD value committed on this edge shows from the next digit.
            idx_d = idx_q + 2'd1;
            if (phase_q == PH_TEXT) begin
                seg_d = text_glyph(idx_q);
                an_d  = ~(4'b0001 << idx_q);
            end else if (blank_cur) begin
                seg_d = GLYPH_BLANK;
                an_d  = 4'hF;
            end else begin
                seg_d = digit_glyph(bcd_q[{idx_q, 2'b00} +: 4]);
                an_d  = ~(4'b0001 << idx_q);
            end

            if (idx_q == 2'd3) begin
                if (!text_en) begin
                    phase_d = PH_NUMBER;
                    frame_d = '0;
                end else if (frame_base == FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = (phase_q == PH_NUMBER) ? PH_TEXT : PH_NUMBER;
                end else begin
                    frame_d = frame_base + FW'(1);
                end
            end
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl with a short refresh divider: vector table of scores with
// their expected scan frames, plus hand-written text-phase and reset-abort sequences.
module tb_score_display_ctrl;

    logic        clk;
    logic        rst;
    logic [13:0] score_in;
    logic        score_valid;
    logic        score_ready;
    logic        text_en;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks;
    int failures;
    int ncyc;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [13:0]      score;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    localparam logic [3:0][3:0] AN_ALL  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][3:0] AN_U    = {4'hF, 4'hF, 4'hF, 4'b1110};
    localparam logic [3:0][3:0] AN_TU   = {4'hF, 4'hF, 4'b1101, 4'b1110};
    localparam logic [3:0][6:0] SEG_0   = {7'h7F, 7'h7F, 7'h7F, 7'b1000000};
    localparam logic [3:0][6:0] SEG_42  = {7'h7F, 7'h7F, 7'b0011001, 7'b0100100};
    localparam logic [3:0][6:0] SEG_TXT = {7'b0010010, 7'b1000110, 7'b0100011, 7'b0101111};

    score_display_ctrl #(
        .REFRESH_DIV      (4),
        .FRAMES_PER_PHASE (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .score_in    (score_in),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .text_en     (text_en),
        .seg         (seg),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    // Scoreboard: pop an expectation when the scan drives the digit it names.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] cur;
        if (!rst && ncyc != 0 && (ncyc % 4) == 0 && exp_q.size() != 0) begin
            cur = 2'(((ncyc / 4) - 1) % 4);
            if (exp_q[0].idx == cur) begin
                e = exp_q.pop_front();
                checks++;
                if (an !== e.an || seg !== e.seg) begin
                    failures++;
                    $display("FAIL digit%0d @cyc%0d: got an=%b seg=%b, want an=%b seg=%b",
                             cur, ncyc, an, seg, e.an, e.seg);
                end
            end
        end
    end

    task automatic check1(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic push_one(input logic [1:0] idx, input logic [3:0] a, input logic [6:0] s);
        exp_t e;
        e.idx = idx;
        e.an  = a;
        e.seg = s;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [3:0][3:0] a, input logic [3:0][6:0] s);
        for (int i = 0; i < 4; i++) push_one(2'(i), a[i], s[i]);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected digits never driven", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_wrap();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ncyc != 0 && (ncyc % 4) == 0 && (((ncyc / 4) - 1) % 4) == 3) && n < 64);
        if (n >= 64) begin
            checks++;
            failures++;
            $display("FAIL wait_wrap: no frame wrap within %0d cycles", n);
        end
    endtask

    // Holds valid with a different value while busy; that value must be ignored.
    task automatic send(input logic [13:0] v);
        int n;
        int lows;
        n = 0;
        while (!score_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        score_in    = v;
        score_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        score_in = 14'd5555;
        lows = 0;
        while (!score_ready && lows < 40) begin
            lows++;
            if (lows == 15) score_valid = 1'b0;
            @(negedge clk);
        end
        score_valid = 1'b0;
        checks++;
        if (lows != 15) begin
            failures++;
            $display("FAIL ready_latency(%0d): got %0d busy cycles, want 15", v, lows);
        end
    endtask

    initial begin
        vecs[0].score = 14'd1234;  vecs[0].an = AN_ALL;
        vecs[0].seg   = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        vecs[1].score = 14'd7;     vecs[1].an = AN_U;
        vecs[1].seg   = {7'h7F, 7'h7F, 7'h7F, 7'b1111000};
        vecs[2].score = 14'd12000; vecs[2].an = AN_ALL;
        vecs[2].seg   = {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};
        vecs[3].score = 14'd0;     vecs[3].an = AN_U;
        vecs[3].seg   = SEG_0;
        vecs[4].score = 14'd1005;  vecs[4].an = AN_ALL;
        vecs[4].seg   = {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010};
        vecs[5].score = 14'd50;    vecs[5].an = AN_TU;
        vecs[5].seg   = {7'h7F, 7'h7F, 7'b0010010, 7'b1000000};
        vecs[6].score = 14'd608;   vecs[6].an = {4'hF, 4'b1011, 4'b1101, 4'b1110};
        vecs[6].seg   = {7'h7F, 7'b0000010, 7'b1000000, 7'b0000000};
        vecs[7].score = 14'd16383; vecs[7].an = AN_ALL;
        vecs[7].seg   = {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000};

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        text_en     = 1'b0;
        score_valid = 1'b0;
        score_in    = '0;
        repeat (3) @(negedge clk);
        check1("reset_an",    {4'h0, an},          8'h0F);
        check1("reset_seg",   {1'b0, seg},         8'h7F);
        check1("reset_ready", {7'h0, score_ready}, 8'h01);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        check1("prescan_an", {4'h0, an}, 8'h0F);
        push_frame(AN_U, SEG_0);
        push_frame(AN_U, SEG_0);
        drain(80);

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].score);
            push_frame(vecs[v].an, vecs[v].seg);
            drain(48);
        end

        // Alternation: two number frames, two text frames, then number again.
        send(14'd42);
        push_frame(AN_TU, SEG_42);
        drain(48);
        wait_wrap();
        text_en = 1'b1;
        push_frame(AN_TU, SEG_42);
        push_frame(AN_TU, SEG_42);
        push_frame(AN_ALL, SEG_TXT);
        push_frame(AN_ALL, SEG_TXT);
        push_frame(AN_TU, SEG_42);
        drain(120);
        text_en = 1'b0;

        // Dropping text_en mid text frame forces NUMBER at the following wrap.
        wait_wrap();
        text_en = 1'b1;
        push_frame(AN_TU, SEG_42);
        push_frame(AN_TU, SEG_42);
        push_one(2'd0, 4'b1110, 7'b0101111);
        drain(64);
        text_en = 1'b0;
        push_one(2'd1, 4'b1101, 7'b0100011);
        push_one(2'd2, 4'b1011, 7'b1000110);
        push_one(2'd3, 4'b0111, 7'b0010010);
        push_frame(AN_TU, SEG_42);
        drain(48);

        // Reset five cycles into a conversion aborts it and clears the display.
        score_in    = 14'd500;
        score_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        score_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check1("abort_an",    {4'h0, an},          8'h0F);
        check1("abort_seg",   {1'b0, seg},         8'h7F);
        check1("abort_ready", {7'h0, score_ready}, 8'h01);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("post_rst_ready", {7'h0, score_ready}, 8'h01);
        push_frame(AN_U, SEG_0);
        drain(48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
